// File: rtl/cd_sector_fifo_if.sv
// Host/drive-side bus of the CD sector FIFO: write strobe, sized reads and status.
interface cd_sector_fifo_if #(
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          clr;
  logic          we;
  logic [7:0]    data_in;
  logic          re;
  logic [1:0]    re_size;
  logic [31:0]   data_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          avail;
  logic          overflow;
  logic          underflow;

  modport master (
    output clr, we, data_in, re, re_size,
    input  data_out, count, full, empty, avail, overflow, underflow
  );

  modport slave (
    input  clr, we, data_in, re, re_size,
    output data_out, count, full, empty, avail, overflow, underflow
  );
endinterface

// File: rtl/cd_sector_fifo.sv
// Byte-in, 8/16/32-bit-out circular FIFO with first-word-fall-through output,
// occupancy count and sticky overflow/underflow flags.
module cd_sector_fifo #(
  parameter int unsigned DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  cd_sector_fifo_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [2:0]    rd_n_c;
  logic          full_c;
  logic          empty_c;
  logic          avail_c;
  logic          wr_acc_c;
  logic          rd_acc_c;
  logic [31:0]   data_out_c;

  // Bytes requested by the current read size; the reserved code reads a word.
  always_comb begin
    rd_n_c = 3'd4;
    case (bus.re_size)
      2'd0:    rd_n_c = 3'd1;
      2'd1:    rd_n_c = 3'd2;
      default: rd_n_c = 3'd4;
    endcase
  end

  // Status and acceptance decisions use the pre-edge count only.
  always_comb begin
    full_c   = (count_q == CW'(DEPTH));
    empty_c  = (count_q == '0);
    avail_c  = (count_q >= CW'(rd_n_c));
    wr_acc_c = bus.we && !full_c;
    rd_acc_c = bus.re && avail_c;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    rp_d        = rp_q;
    wp_d        = wp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clr) begin
      rp_d        = '0;
      wp_d        = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc_c) begin
        wp_d = wp_q + AW'(1);
      end
      if (bus.we && full_c) begin
        overflow_d = 1'b1;
      end
      if (rd_acc_c) begin
        rp_d = rp_q + AW'(rd_n_c);
      end
      if (bus.re && !avail_c) begin
        underflow_d = 1'b1;
      end
      count_d = count_q + CW'(wr_acc_c) - (rd_acc_c ? CW'(rd_n_c) : CW'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q        <= '0;
      wp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rp_q        <= rp_d;
      wp_q        <= wp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; stale bytes are masked by count on the output.
  always_ff @(posedge clk) begin
    if (wr_acc_c && !bus.clr) begin
      mem_q[wp_q] <= bus.data_in;
    end
  end

  // Up to four oldest bytes, little-endian, wrapping across the array end.
  always_comb begin
    data_out_c = '0;
    for (int k = 0; k < 4; k++) begin
      if (CW'(k) < count_q) begin
        data_out_c[8*k +: 8] = mem_q[rp_q + AW'(k)];
      end
    end
  end

  assign bus.data_out  = data_out_c;
  assign bus.count     = count_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.avail     = avail_c;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_cd_sector_fifo.sv
// Directed plus randomized bench for cd_sector_fifo against a byte-queue model.
module tb_cd_sector_fifo;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cd_sector_fifo_if #(.DEPTH(DEPTH)) bus ();
  cd_sector_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  byte unsigned mq[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  int n_assert = 0;
  int n_fail = 0;

  function automatic int unsigned size_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] d = '0;
    for (int k = 0; k < 4; k++)
      if (k < mq.size()) d[8*k +: 8] = mq[k];
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".count"},     32'(bus.count),     32'(mq.size()));
    chk({where, ".full"},      32'(bus.full),      32'(mq.size() == DEPTH));
    chk({where, ".empty"},     32'(bus.empty),     32'(mq.size() == 0));
    chk({where, ".avail"},     32'(bus.avail),     32'(mq.size() >= size_bytes(bus.re_size)));
    chk({where, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    chk({where, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
    chk({where, ".data_out"},  bus.data_out,       exp_data());
  endtask

  // Reference behaviour on the contents seen before the edge.
  task automatic model_step(input logic we, input logic [7:0] din, input logic re,
                            input logic [1:0] sz, input logic clr);
    int unsigned n = size_bytes(sz);
    bit was_full = (mq.size() == DEPTH);
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (re) begin
        if (mq.size() >= n) begin
          for (int i = 0; i < int'(n); i++) void'(mq.pop_front());
        end else m_unf = 1'b1;
      end
      if (we) begin
        if (!was_full) mq.push_back(din);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic we, input logic [7:0] din, input logic re,
                       input logic [1:0] sz, input logic clr, input string where);
    bus.we = we; bus.data_in = din; bus.re = re; bus.re_size = sz; bus.clr = clr;
    model_step(we, din, re, sz, clr);
    @(posedge clk); #1;
    check_all(where);
  endtask

  task automatic wr(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 2'd0, 1'b0, "wr");
  endtask

  task automatic rd(input logic [1:0] sz);
    cycle(1'b0, 8'h00, 1'b1, sz, 1'b0, "rd");
  endtask

  task automatic flush();
    cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, "clr");
  endtask

  initial begin
    bus.clr = 1'b0; bus.we = 1'b0; bus.data_in = 8'h00; bus.re = 1'b0; bus.re_size = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.data_out", bus.data_out, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic order
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    bus.re_size = 2'd2; #1;
    chk("basic.data", bus.data_out, 32'h44332211);
    chk("basic.count", 32'(bus.count), 32'd4);
    chk("basic.avail32", 32'(bus.avail), 32'd1);
    rd(2'd2);
    chk("basic.empty", 32'(bus.empty), 32'd1);
    chk("basic.drained", bus.data_out, 32'h0);

    // Mixed widths
    for (int i = 1; i <= 6; i++) wr(8'(i));
    rd(2'd0);
    chk("mixed.rd8", 32'(bus.data_out[7:0]), 32'h02);
    rd(2'd1);
    chk("mixed.rd16", 32'(bus.data_out[15:0]), 32'h0504);
    rd(2'd2);
    chk("mixed.underflow", 32'(bus.underflow), 32'd1);
    chk("mixed.count", 32'(bus.count), 32'd3);
    flush();

    // Fill and overflow
    for (int i = 0; i <= 32; i++) wr(8'(i));
    chk("fill.full", 32'(bus.full), 32'd1);
    chk("fill.count", 32'(bus.count), 32'd32);
    chk("fill.overflow", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("fill.drain", bus.data_out, 32'h03020100 + 32'h04040404 * 32'(i));
      rd(2'd2);
    end
    chk("fill.empty", 32'(bus.empty), 32'd1);
    flush();

    // Wrap-around
    for (int i = 0; i < 30; i++) wr(8'(i));
    for (int i = 0; i < 7; i++) rd(2'd2);
    for (int i = 0; i < 6; i++) wr(8'(8'hA0 + i));
    chk("wrap.count", 32'(bus.count), 32'd8);
    chk("wrap.first", bus.data_out, 32'hA1A01D1C);
    rd(2'd2);
    chk("wrap.last", bus.data_out, 32'hA5A4A3A2);
    rd(2'd2);
    chk("wrap.empty", 32'(bus.empty), 32'd1);

    // Simultaneous read/write
    flush();
    for (int i = 0; i < 5; i++) wr(8'(8'h50 + i));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'(8'h60 + i), 1'b1, 2'd1, 1'b0, "simul");
      if (i < 4) chk("simul.count", 32'(bus.count), 32'(4 - i));
    end
    chk("simul.underflow", 32'(bus.underflow), 32'd1);

    // Empty with simultaneous byte read and write
    flush();
    cycle(1'b1, 8'h77, 1'b1, 2'd0, 1'b0, "empty_rw");
    chk("empty_rw.count", 32'(bus.count), 32'd1);
    chk("empty_rw.underflow", 32'(bus.underflow), 32'd1);

    // Full: same-cycle read and write, the write is dropped
    flush();
    for (int i = 0; i < 32; i++) wr(8'(8'h80 + i));
    cycle(1'b1, 8'hFF, 1'b1, 2'd0, 1'b0, "full_rw");
    chk("full_rw.count", 32'(bus.count), 32'd31);
    chk("full_rw.overflow", 32'(bus.overflow), 32'd1);

    // Flush with both flags set
    flush();
    rd(2'd0);
    for (int i = 0; i <= 32; i++) wr(8'(8'hC0 + i));
    for (int i = 0; i < 5; i++) rd(2'd2);
    chk("flush.pre_count", 32'(bus.count), 32'd12);
    cycle(1'b1, 8'hEE, 1'b0, 2'd0, 1'b1, "flush");
    chk("flush.count", 32'(bus.count), 32'd0);
    chk("flush.ovf", 32'(bus.overflow), 32'd0);
    chk("flush.unf", 32'(bus.underflow), 32'd0);

    // Asynchronous reset between edges
    for (int i = 0; i < 7; i++) wr(8'(8'h30 + i));
    rd(2'd3);
    bus.we = 1'b0; bus.re = 1'b0; bus.clr = 1'b0; bus.re_size = 2'd2;
    #2 rst = 1'b1;
    #1;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_all("async_rst");
    chk("async_rst.data_out", bus.data_out, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic we_r  = ($urandom_range(0, 99) < ((i < 300) ? 70 : 30));
      logic re_r  = ($urandom_range(0, 99) < 50);
      logic clr_r = ($urandom_range(0, 199) == 0);
      cycle(we_r, 8'($urandom), re_r, 2'($urandom), clr_r, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cd_sector_fifo.md
# cd_sector_fifo

Parametrised byte-in, multi-width-out FIFO for the CD-ROM controller data path. The drive side writes sector bytes one at a time. The host side reads 8, 16 or 32 bits per access in first-word-fall-through fashion. Compared with the fixed 16-entry byte/halfword buffer it replaces, it adds:

- configurable depth;
- a true circular buffer with wrap-around;
- simultaneous read and write;
- an occupancy count;
- sticky overflow and underflow error flags.

## Interface
Parameters:
- DEPTH, 32, storage in bytes; power of two, 8 to 4096
- CW, $clog2(DEPTH)+1, width of count (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous flush of pointers, count and error flags
- we  in  1  write strobe, one byte per cycle
- data_in  in  8  write byte
- re  in  1  read strobe
- re_size  in  2  read width: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = reserved (treated as 4 bytes)
- data_out  out  32  next up-to-4 bytes, little-endian (bits 7:0 = oldest byte)
- count  out  CW  bytes currently stored, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- avail  out  1  count >= bytes implied by current re_size
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was dropped

## Operation
**Storage and pointers**
- DEPTH x 8 storage array.
- Read pointer rp and write pointer wp, each log2(DEPTH) bits, wrapping modulo DEPTH.
- count is a separate CW-bit register.

**Write**
- Accepted when we=1 and full=0 (full sampled before the edge, regardless of any same-cycle read).
- On acceptance: mem[wp] <= data_in and wp <= wp+1.
- If we=1 and full=1: the write is dropped, memory and wp are unchanged, and overflow <= 1.

**Read**
- Let n = 1, 2 or 4 from re_size.
- Accepted when re=1 and count >= n. On acceptance rp <= rp+n, with modulo wrap.
- If re=1 and count < n: nothing is consumed, rp is unchanged, and underflow <= 1.
- No partial reads.

**Count update**
- count_next = count + (write accepted ? 1 : 0) - (read accepted ? n : 0).
- Simultaneous accepted read and write are legal and both take effect in the same edge.

**data_out**
- Combinational from mem and rp: byte k (k = 0..3) = mem[(rp+k) mod DEPTH] when k < count, else 8'h00.
- Wrap-around across the end of the array is seamless.

**Clear and reset**
- clr has priority over we and re.
- On clr: rp, wp and count go to 0; overflow and underflow go to 0; memory contents are not cleared (don't-care).
- rst performs the same actions asynchronously.
- Reset values: count=0, empty=1, full=0, avail=0, overflow=0, underflow=0, data_out=32'h0.

**Status outputs**
- full, empty and avail are combinational from registered count and the current re_size.

## Timing
- Write latency: a byte accepted at edge N is visible on data_out and in count from after edge N. There is no extra pipeline stage.
- Read: data_out shows the bytes to be consumed before the read edge. After the edge it shows the following bytes.
- Full-to-not-full: a read at edge N makes full=0 after edge N. A write in the same cycle as that read, while full=1, is still dropped.
- Empty plus simultaneous we and re (n=1): the read is rejected with underflow, the write is accepted, and count becomes 1.
- Error flags stay set until clr or rst. They are not cleared by subsequent successful accesses.
- rst asserted mid-stream: all state is cleared immediately and outputs take their reset values without waiting for a clock edge.

## Test plan
- **Reset, then basic FIFO order:** write 8'h11, 8'h22, 8'h33, 8'h44 -> count=4, data_out=32'h44332211, avail=1 for re_size=2. One 32-bit read -> count=0, empty=1, data_out=0.
- **Mixed widths:** write bytes 01..06. Read 8-bit -> data_out[7:0]=02. Read 16-bit -> data_out[15:0]=16'h0504. Read 32-bit -> underflow=1, count stays 3.
- **Fill and overflow (DEPTH=32):** write 33 bytes 00..20 -> full=1, count=32, overflow=1, and byte 20 is never output. Draining with 8 x 32-bit reads yields 00..1F in order.
- **Wrap-around:** write 30 bytes, read 28, then write 6 bytes 0xA0..A5 -> count=8. A 32-bit read returns the 2 remaining old bytes followed by A0, A1. The last 32-bit read returns 32'hA5A4A3A2.
- **Simultaneous access:** with count=5, assert we and re (re_size=1) every cycle for 10 cycles -> count decreases by 1 per cycle until count<2. The rejected cycle sets underflow, and data order is preserved.
- **Flush and reset:** with count=12 and both error flags set, pulse clr together with we=1 -> count=0, flags=0, write ignored. Assert rst asynchronously between edges -> outputs reach reset values before the next edge.
